pktbuf_sched: RTL

- Sequencer for the three packet buffers (ping=1, pang=2, pung=3).
- Hands buffers around the pipeline snooper -> CPU -> forwarder and drives the 2-bit agent selects (sn_sel, cpu_sel, fwd_sel) consumed by the buffer mux fabric; 0 means no buffer.
- Preserves packet order: the CPU and the forwarder see buffers in the order the snooper finished them.

---
 rtl/pktbuf_sched.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pktbuf_sched.sv
// Packet-buffer sequencer: hands three buffers snooper -> CPU -> forwarder in order.
// Define PKTBUF_SCHED_STATS_EN to add the n_acc/n_rej/n_fwd statistics counters.
module pktbuf_sched #(
    parameter int unsigned NBUF      = 3,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sn_done,
    input  logic                 cpu_acc,
    input  logic                 cpu_rej,
    input  logic                 fwd_done,
    output logic [1:0]           sn_sel,
    output logic [1:0]           cpu_sel,
    output logic [1:0]           fwd_sel,
    output logic                 sn_rdy,
    output logic                 cpu_rdy,
    output logic                 fwd_rdy,
    output logic                 err
`ifdef PKTBUF_SCHED_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] n_acc,
    output logic [CNT_WIDTH-1:0] n_rej,
    output logic [CNT_WIDTH-1:0] n_fwd
`endif
);

    typedef enum logic [2:0] {FREE, SN, WAIT_CPU, CPU, WAIT_FWD, FWD} buf_state_t;

    buf_state_t st   [1:NBUF];
    buf_state_t st_n [1:NBUF];
    logic [1:0] cq   [NBUF];
    logic [1:0] cq_n [NBUF];
    logic [1:0] fq   [NBUF];
    logic [1:0] fq_n [NBUF];
    logic [1:0] cc, cc_n, fc, fc_n;
    logic [1:0] sn_sel_n, cpu_sel_n, fwd_sel_n;
    logic [1:0] free_idx;
    logic       free_found;
    logic       sn_rel, acc_v, rej_v, fwd_v, cpu_pop, fwd_pop, perr;

    assign sn_rdy  = (sn_sel != 2'd0);
    assign cpu_rdy = (cpu_sel != 2'd0);
    assign fwd_rdy = (fwd_sel != 2'd0);

    assign sn_rel  = sn_done && sn_rdy;
    assign rej_v   = cpu_rej && cpu_rdy;
    assign acc_v   = cpu_acc && !cpu_rej && cpu_rdy;
    assign fwd_v   = fwd_done && fwd_rdy;
    assign cpu_pop = !cpu_rdy && (cc != 2'd0);
    assign fwd_pop = !fwd_rdy && (fc != 2'd0);
    assign perr    = (sn_done && !sn_rdy) || ((cpu_acc || cpu_rej) && !cpu_rdy)
                   || (cpu_acc && cpu_rej) || (fwd_done && !fwd_rdy);

    always_comb begin
        free_idx   = 2'd0;
        free_found = 1'b0;
        for (int unsigned i = 1; i <= NBUF; i++) begin
            if (st[i] == FREE && !free_found) begin
                free_idx   = 2'(i);
                free_found = 1'b1;
            end
        end
    end

    // Pop shifts the queue first so a same-cycle push lands behind the survivors.
    always_comb begin
        st_n      = st;
        cq_n      = cq;
        cc_n      = cc;
        fq_n      = fq;
        fc_n      = fc;
        sn_sel_n  = sn_sel;
        cpu_sel_n = cpu_sel;
        fwd_sel_n = fwd_sel;

        if (cpu_pop) begin
            for (int unsigned i = 0; i < NBUF - 1; i++) cq_n[i] = cq[i+1];
            cq_n[NBUF-1] = '0;
            cc_n         = cc - 2'd1;
            cpu_sel_n    = cq[0];
            st_n[cq[0]]  = CPU;
        end
        if (fwd_pop) begin
            for (int unsigned i = 0; i < NBUF - 1; i++) fq_n[i] = fq[i+1];
            fq_n[NBUF-1] = '0;
            fc_n         = fc - 2'd1;
            fwd_sel_n    = fq[0];
            st_n[fq[0]]  = FWD;
        end

        if (sn_rel) begin
            if (cc_n < 2'(NBUF)) cq_n[cc_n] = sn_sel;
            cc_n         = cc_n + 2'd1;
            st_n[sn_sel] = WAIT_CPU;
            sn_sel_n     = '0;
        end
        if (acc_v) begin
            if (fc_n < 2'(NBUF)) fq_n[fc_n] = cpu_sel;
            fc_n          = fc_n + 2'd1;
            st_n[cpu_sel] = WAIT_FWD;
            cpu_sel_n     = '0;
        end
        if (rej_v) begin
            st_n[cpu_sel] = FREE;
            cpu_sel_n     = '0;
        end
        if (fwd_v) begin
            st_n[fwd_sel] = FREE;
            fwd_sel_n     = '0;
        end

        if (!sn_rdy && free_found) begin
            st_n[free_idx] = SN;
            sn_sel_n       = free_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i <= NBUF; i++) st[i] <= FREE;
            for (int unsigned i = 0; i < NBUF; i++) begin
                cq[i] <= '0;
                fq[i] <= '0;
            end
            cc      <= '0;
            fc      <= '0;
            sn_sel  <= '0;
            cpu_sel <= '0;
            fwd_sel <= '0;
            err     <= 1'b0;
        end else begin
            st      <= st_n;
            cq      <= cq_n;
            fq      <= fq_n;
            cc      <= cc_n;
            fc      <= fc_n;
            sn_sel  <= sn_sel_n;
            cpu_sel <= cpu_sel_n;
            fwd_sel <= fwd_sel_n;
            err     <= err | perr;
        end
    end

`ifdef PKTBUF_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            n_acc <= '0;
            n_rej <= '0;
            n_fwd <= '0;
        end else begin
            if (acc_v) n_acc <= n_acc + 1'b1;
            if (rej_v) n_rej <= n_rej + 1'b1;
            if (fwd_v) n_fwd <= n_fwd + 1'b1;
        end
    end
`endif

endmodule
